// File: rtl/clockdiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clockdiv_pkg
//  Description : Shared types, constants and helpers for the programmable
//                integer clock divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package clockdiv_pkg;

    // Divider control state: parked, running, running with a reload queued.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        RUN_PEND = 2'd2
    } state_e;

    // Smallest divisor that still produces a toggling output.
    localparam int MIN_DIV = 2;

    // Working width of half_ceil; divisor widths up to this value are supported.
    localparam int HC_W = 32;

    // Number of high cycles in a period: ceil(d/2). One guard bit above the
    // operand keeps d = all-ones from wrapping to zero before the shift.
    function automatic logic [HC_W:0] half_ceil(input logic [HC_W-1:0] d);
        logic [HC_W:0] sum;
        sum = {1'b0, d} + {{HC_W{1'b0}}, 1'b1};
        return sum >> 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clockdiv_prog.sv
`default_nettype none
// ============================================================================
//  Module      : clockdiv_prog
//  Description : Runtime-programmable integer clock divider. Produces a
//                registered divided clock and a period-start strobe; the
//                divisor is reloaded via valid/ready and takes effect only on
//                a period boundary so the output never glitches.
//  Revision    : 1.0 - initial release
// ============================================================================
module clockdiv_prog
    import clockdiv_pkg::*;
#(
    parameter int WIDTH       = 8,   // divisor / counter width, at most HC_W
    parameter int DEFAULT_DIV = 10   // divisor after reset, 2..2^WIDTH-1
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             phase_clr,
    input  logic [WIDTH-1:0] div_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             load_err,
    output logic [WIDTH-1:0] div_cur,
    output logic             clk_out,
    output logic             tick
);

    localparam logic [WIDTH-1:0] C_DEFAULT_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] C_MIN_DIV     = WIDTH'(MIN_DIV);
    localparam logic [WIDTH-1:0] C_ONE         = WIDTH'(1);
    localparam logic [WIDTH-1:0] C_ZERO        = '0;

    // Registered state
    state_e           r_state_q;
    logic [WIDTH-1:0] r_cnt_q;
    logic [WIDTH-1:0] r_div_q;
    logic [WIDTH-1:0] r_pend_q;
    logic             r_clk_out_q;
    logic             r_tick_q;
    logic             r_load_err_q;

    // Next-state values
    state_e           w_state_d;
    logic [WIDTH-1:0] w_cnt_d;
    logic [WIDTH-1:0] w_div_d;
    logic [WIDTH-1:0] w_pend_d;
    logic             w_clk_out_d;
    logic             w_tick_d;
    logic             w_load_err_d;

    // Decoded conditions
    logic             w_accept;     // handshake completes this cycle
    logic             w_div_ok;     // requested divisor is usable
    logic             w_accept_ok;  // accepted and usable
    logic             w_last;       // counter at the final count of the period
    logic             w_restart;    // counter returns to 0 next cycle
    logic [HC_W:0]    w_high;       // high-phase length of the current divisor
    logic             w_in_high;    // counter lies in the high phase

    // The pending slot is busy only while a reload is queued.
    assign load_ready  = (r_state_q != RUN_PEND);
    assign w_accept    = load_valid && load_ready;
    assign w_div_ok    = (div_in >= C_MIN_DIV);
    assign w_accept_ok = w_accept && w_div_ok;

    assign w_last    = (r_cnt_q == (r_div_q - C_ONE));
    assign w_restart = w_last || phase_clr;
    assign w_high    = half_ceil(HC_W'(r_div_q));
    assign w_in_high = ({1'b0, HC_W'(r_cnt_q)} < w_high);

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_state_q    <= IDLE;
            r_cnt_q      <= C_ZERO;
            r_div_q      <= C_DEFAULT_DIV;
            r_pend_q     <= C_DEFAULT_DIV;
            r_clk_out_q  <= 1'b0;
            r_tick_q     <= 1'b0;
            r_load_err_q <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_cnt_q      <= w_cnt_d;
            r_div_q      <= w_div_d;
            r_pend_q     <= w_pend_d;
            r_clk_out_q  <= w_clk_out_d;
            r_tick_q     <= w_tick_d;
            r_load_err_q <= w_load_err_d;
        end
    end

    // Next-state logic: enable low always parks the divider.
    always_comb begin
        w_state_d = r_state_q;
        if (!enable) begin
            w_state_d = IDLE;
        end else begin
            case (r_state_q)
                IDLE:     w_state_d = RUN;
                RUN:      if (w_accept_ok) w_state_d = RUN_PEND;
                RUN_PEND: if (w_restart)   w_state_d = RUN;
                default:  w_state_d = IDLE;
            endcase
        end
    end

    // Counter, divisor/pending update and registered output values.
    always_comb begin
        w_cnt_d      = r_cnt_q;
        w_div_d      = r_div_q;
        w_pend_d     = r_pend_q;
        w_clk_out_d  = 1'b0;
        w_tick_d     = 1'b0;
        w_load_err_d = w_accept && !w_div_ok;

        if (!enable) begin
            // Parking resets the phase, so any divisor change is safe here:
            // a queued reload is committed, otherwise a fresh load applies.
            w_cnt_d = C_ZERO;
            if (r_state_q == RUN_PEND) begin
                w_div_d = r_pend_q;
            end else if (w_accept_ok) begin
                w_div_d = div_in;
            end
        end else begin
            w_clk_out_d = w_in_high;
            w_tick_d    = (r_cnt_q == C_ZERO);
            w_cnt_d     = w_restart ? C_ZERO : (r_cnt_q + C_ONE);
            case (r_state_q)
                // Counter is 0 here, so a direct apply cannot overrun it.
                IDLE:     if (w_accept_ok) w_div_d  = div_in;
                RUN:      if (w_accept_ok) w_pend_d = div_in;
                RUN_PEND: if (w_restart)   w_div_d  = r_pend_q;
                default:  ;
            endcase
        end
    end

    assign load_err = r_load_err_q;
    assign div_cur  = r_div_q;
    assign clk_out  = r_clk_out_q;
    assign tick     = r_tick_q;

endmodule
`default_nettype wire

// File: doc/clockdiv_prog.md
Name: clockdiv_prog

Overview:
- Runtime-programmable integer clock divider; next generation of the fixed 10:1 divider.
- Produces a registered divided clock `clk_out` and a one-cycle `tick` strobe at each period start.
- Divisor is WIDTH bits wide and can be reloaded through a valid/ready handshake; reloads take effect glitch-free on a period boundary.
- Used as the timebase generator for blinkers, UART baud and display multiplexing.

Parameters:
- WIDTH, 8: divisor and counter width in bits.
- DEFAULT_DIV, 10: divisor after reset; must satisfy 2 <= DEFAULT_DIV <= 2^WIDTH-1.

Ports:
- clk_in  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- enable  input  1  1 = divider runs; 0 = output parked low.
- phase_clr  input  1  restarts the period at counter 0.
- div_in  input  WIDTH  requested divisor.
- load_valid  input  1  div_in valid.
- load_ready  output  1  pending slot free; a transfer occurs when load_valid && load_ready.
- load_err  output  1  one-cycle pulse: rejected load (div_in < 2).
- div_cur  output  WIDTH  divisor currently in force.
- clk_out  output  1  divided clock.
- tick  output  1  one-cycle pulse coincident with each clk_out rising period start.

Behaviour:
- Clock and reset: one clock (clk_in); reset rst_n is synchronous, active-low.
- Reset values (rst_n=0 sampled): counter=0, div_cur=DEFAULT_DIV, pending empty, load_ready=1, load_err=0, clk_out=0, tick=0, state=IDLE. Any pending load is discarded.
- Counter: counts 0..div_cur-1, then wraps to 0.
- HIGH = (div_cur+1)>>1, computed in WIDTH+1 bits so div_cur=2^WIDTH-1 does not overflow.
- Registered outputs, one cycle of latency: if the counter equals c in cycle k, then in cycle k+1:
  - clk_out = (c < HIGH);
  - tick = (c == 0).
- Duty cycle: even D gives exactly 50%; odd D gives HIGH = (D+1)/2 cycles high and (D-1)/2 cycles low.
- FSM states:
  - IDLE: enable=0.
  - RUN: enable=1, no pending load.
  - RUN_PEND: enable=1, pending load held.
- FSM transitions:
  - IDLE -> RUN when enable=1. The counter starts at 0, so the first tick/clk_out high appears the cycle after enable is first sampled high.
  - Any state -> IDLE when enable=0. Next cycle: counter=0, clk_out=0, tick=0.
  - RUN -> RUN_PEND on an accepted valid load.
  - RUN_PEND -> RUN when the pending value is applied.
- Load acceptance (load_valid && load_ready):
  - div_in >= 2: captured into pending; load_ready=0 from the next cycle.
  - div_in < 2: load_err=1 next cycle for one cycle; nothing captured; load_ready stays 1.
- Pending apply:
  - In RUN_PEND, when counter == div_cur-1 (or phase_clr=1): next cycle counter=0, div_cur=pending, load_ready=1.
  - In IDLE, an accepted load is applied in the next cycle directly (div_cur updated, load_ready stays 1).
- phase_clr=1 while enabled: counter forced to 0 next cycle, so tick fires the cycle after. phase_clr while enable=0 has no effect.
- Simultaneous events:
  - enable=0 with phase_clr: enable=0 wins.
  - A load accepted in the same cycle as a period end is applied at the following period end, not the current one.
  - rst_n=0 overrides everything.
- clk_out never glitches: it is a flop output, and divisor changes only occur at counter=0.

Decomposition:
- Shared package clockdiv_pkg holds:
  - state enum {IDLE, RUN, RUN_PEND};
  - MIN_DIV = 2;
  - function half_ceil(d) returning (d+1)>>1 in WIDTH+1 bits.
- No sub-module; the counter, load controller and output stage fit in one module.

Test Plan:
- Reset defaults: rst_n low 3 cycles, then high with enable=1, DEFAULT_DIV=10 -> clk_out high in cycles 1-5 and low in cycles 6-10 after release; tick at cycles 1, 11, 21; div_cur=10.
- Odd divisor: load 5 while IDLE, then enable -> period 5, clk_out high 3 / low 2, tick every 5 cycles; div_cur=5 one cycle after the load.
- Mid-period reload: running at 10, load 4 at counter=3 -> load_ready=0 until the period ends; next period is 4 cycles (2 high / 2 low); load_ready returns to 1; a second load while pending is not accepted.
- Rejected load: div_in=1 and then div_in=0 with load_valid -> load_err pulses once per attempt; div_cur and the clk_out waveform are unchanged; load_ready stays 1.
- Enable and phase_clr: drop enable at counter=2 -> clk_out=0 next cycle. Re-enable -> tick the cycle after. phase_clr at counter=7 -> tick 2 cycles later and the period restarts.
- Width boundary: WIDTH=8, load 255 -> clk_out high 128 / low 127 cycles, no wrap error. Assert rst_n=0 mid-period with a load pending -> div_cur=DEFAULT_DIV and the pending load is dropped.
